game_sequencer: RTL
===================

GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 The block SHALL have parameter GRAVITY_TICKS, default 25000000, clock cycles between automatic drops (minimum 2).
REQ-002 The block SHALL have parameter SCORE_W, default 16, width of the score counter.
REQ-003 The block SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1: single-cycle pulse that starts a game from IDLE or OVER.
REQ-006 The block SHALL have ports btnLeft, btnRight, btnDown, btnRotate, input, 1 each: debounced single-cycle user request pulses.
REQ-007 The block SHALL have port bottomTouch, input, 1: field reports that the last down command landed the block.
REQ-008 The block SHALL have port fieldFull, input, 1: field reports that the spawn area is occupied.
REQ-009 The block SHALL have port linesCleared, input, 3: number of rows cleared by the last landing (0-4); valid with bottomTouch.
REQ-010 The block SHALL have ports leftTrue, rightTrue, downTrue, rotateTrue, output, 1 each: single-cycle command strobes to the field.
REQ-011 The block SHALL have port nextBlockTrue, output, 1: single-cycle spawn strobe.
REQ-012 The block SHALL have port blockType, output, 3: shape index 0-4, stable while nextBlockTrue is high.
REQ-013 The block SHALL have port gameOver, output, 1: high in state OVER.
REQ-014 The block SHALL have port score, output, SCORE_W: accumulated cleared lines.

Function
REQ-015 The FSM SHALL use states IDLE, SPAWN, PLAY, WAIT and OVER.
REQ-016 Transitions: IDLE -> SPAWN on start; SPAWN -> OVER if fieldFull, else -> PLAY; PLAY -> WAIT when any command strobe is issued; WAIT -> SPAWN if bottomTouch, else -> PLAY; OVER -> SPAWN on start.
REQ-017 nextBlockTrue SHALL be high exactly for the one cycle spent in SPAWN.
REQ-018 At most one command strobe SHALL be high in any cycle, and only in PLAY.
REQ-019 WAIT SHALL last exactly one cycle, so commands are spaced at least 2 cycles apart.
REQ-020 Each button SHALL set its own one-deep pending flag in any state except IDLE/OVER; the flag clears when its command is issued, and repeated pulses while set are dropped.
REQ-021 The gravity counter SHALL count only in PLAY and WAIT; on reaching GRAVITY_TICKS-1 it sets gravityPending and wraps to 0.
REQ-022 Issuing downTrue for any reason SHALL zero the gravity counter and clear both gravityPending and the pending down flag.
REQ-023 Arbitration priority in PLAY SHALL be: gravity/down > rotate > left > right.
REQ-024 On entering SPAWN, all pending flags and the gravity counter SHALL clear.
REQ-025 blockType SHALL come from a free-running counter 0,1,2,3,4,0,… that advances every cycle, including in IDLE; it is sampled into a register on entry to SPAWN.
REQ-026 When bottomTouch is sampled in WAIT, score SHALL add linesCleared, saturating at all-ones.
REQ-027 start SHALL zero score when leaving IDLE or OVER.
REQ-028 start SHALL be ignored in SPAWN, PLAY and WAIT.
REQ-029 bottomTouch SHALL be ignored outside WAIT.

Reset
REQ-030 Reset SHALL force state IDLE, all strobes 0, gameOver 0, score 0, pending flags 0, gravity counter 0, shape counter 0 and blockType 0.
REQ-031 Reset SHALL take priority over every other input in the same cycle, including mid-command (WAIT) and mid-spawn.

Structure
REQ-032 The state encoding, shape count (5) and command priority constants SHALL live in the shared package tetris_pkg.
REQ-033 The gravity timer SHALL be one sub-module, gravity_timer (parameter TICKS; inputs clear and enable; output tick).
REQ-034 All other logic SHALL be flat within game_sequencer.

Verification (GRAVITY_TICKS=4)
REQ-035 Reset, then start -> nextBlockTrue for 1 cycle 2 cycles later, blockType equals the counter value at SPAWN entry, then PLAY.
REQ-036 No buttons in PLAY -> downTrue every 5 cycles (4 ticks + WAIT), never two strobes in one cycle.
REQ-037 btnLeft and btnRotate in the same cycle -> rotateTrue then leftTrue, 2 cycles apart; a second btnLeft while pending -> only one leftTrue.
REQ-038 downTrue, then bottomTouch=1 with linesCleared=3 in WAIT -> score increments by 3, then SPAWN.
REQ-039 Score at 0xFFFE plus linesCleared=4 -> score = 0xFFFF.
REQ-040 fieldFull=1 at SPAWN -> gameOver=1, no strobes; start -> score=0, SPAWN. Separately, reset asserted in WAIT -> IDLE next cycle with all outputs 0.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared definitions for the game sequencer: FSM state encoding, shape count,
// and the command vector layout whose bit order is the arbitration priority.
package tetris_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_PLAY  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int unsigned NUM_SHAPES = 5;
  localparam int unsigned SHAPE_W    = 3;
  localparam int unsigned LINES_W    = 3;

  // Command vector: bit index is priority rank, lowest index wins.
  localparam int unsigned CMD_W       = 4;
  localparam int unsigned PRIO_DOWN   = 0;
  localparam int unsigned PRIO_ROTATE = 1;
  localparam int unsigned PRIO_LEFT   = 2;
  localparam int unsigned PRIO_RIGHT  = 3;

  typedef logic [CMD_W-1:0] cmd_vec_t;

  // Grant the highest-priority (lowest-index) request, at most one bit set.
  function automatic cmd_vec_t pick_cmd(input cmd_vec_t req);
    return req & (~req + CMD_W'(1));
  endfunction

endpackage

// File: rtl/gravity_timer.sv
// Gravity timer: counts enabled cycles and flags every TICKS-th one.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   clear        : zero the count (wins over enable)
//   enable       : advance the count this cycle
//   tick         : count is at its last value while enabled (wraps on this edge)
module gravity_timer #(
  parameter int unsigned TICKS = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Next count: clear first, then wrap or increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game sequencer: sequences spawn/play/wait/over phases of a falling-block game,
// arbitrates user and gravity commands into single-cycle strobes, keeps score.
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   start                         : start pulse (honoured in IDLE/OVER only)
//   btnLeft/Right/Down/Rotate     : user request pulses
//   bottomTouch, linesCleared     : landing report from the field (used in WAIT)
//   fieldFull                     : spawn area occupied (checked in SPAWN)
//   leftTrue/rightTrue/downTrue/rotateTrue : command strobes, only in PLAY
//   nextBlockTrue, blockType      : spawn strobe and shape index
//   gameOver, score               : game-over flag and saturating line count
module game_sequencer
  import tetris_pkg::*;
#(
  parameter int unsigned GRAVITY_TICKS = 25000000,
  parameter int unsigned SCORE_W       = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               btnLeft,
  input  logic               btnRight,
  input  logic               btnDown,
  input  logic               btnRotate,
  input  logic               bottomTouch,
  input  logic               fieldFull,
  input  logic [LINES_W-1:0] linesCleared,
  output logic               leftTrue,
  output logic               rightTrue,
  output logic               downTrue,
  output logic               rotateTrue,
  output logic               nextBlockTrue,
  output logic [SHAPE_W-1:0] blockType,
  output logic               gameOver,
  output logic [SCORE_W-1:0] score
);

  state_e             state_q, state_d;
  cmd_vec_t           pend_q, pend_d;
  cmd_vec_t           strobe_q, strobe_d;
  logic               grav_pend_q, grav_pend_d;
  logic [SHAPE_W-1:0] shape_q, shape_d;
  logic [SHAPE_W-1:0] block_type_q, block_type_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               next_block_q, next_block_d;
  logic               game_over_q, game_over_d;

  logic               enter_spawn;
  logic               grav_tick;
  logic               grav_en;
  logic               grav_clear;
  cmd_vec_t           btn_vec;
  cmd_vec_t           req;
  logic [SCORE_W:0]   score_sum;

  assign grav_en    = (state_q == ST_PLAY) || (state_q == ST_WAIT);
  assign grav_clear = enter_spawn || strobe_q[PRIO_DOWN];
  assign score_sum  = {1'b0, score_q} + (SCORE_W + 1)'(linesCleared);

  gravity_timer #(
    .TICKS (GRAVITY_TICKS)
  ) u_gravity_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (grav_clear),
    .enable (grav_en),
    .tick   (grav_tick)
  );

  // Next-state, pending flags, arbitration and registered-output values.
  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    block_type_d = block_type_q;
    shape_d      = (shape_q == SHAPE_W'(NUM_SHAPES - 1)) ? '0 : shape_q + SHAPE_W'(1);
    btn_vec      = '0;
    req          = '0;
    strobe_d     = '0;

    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d = ST_SPAWN;
          score_d = '0;
        end
      end
      ST_SPAWN: state_d = fieldFull ? ST_OVER : ST_PLAY;
      ST_PLAY: begin
        if (|strobe_q) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bottomTouch) begin
          state_d = ST_SPAWN;
          score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        end else begin
          state_d = ST_PLAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    enter_spawn = (state_d == ST_SPAWN);
    if (enter_spawn) block_type_d = shape_q;

    // Buttons only register during a game; a press on an already-set or
    // just-issued flag is dropped.
    if ((state_q == ST_SPAWN) || (state_q == ST_PLAY) || (state_q == ST_WAIT)) begin
      btn_vec[PRIO_DOWN]   = btnDown;
      btn_vec[PRIO_ROTATE] = btnRotate;
      btn_vec[PRIO_LEFT]   = btnLeft;
      btn_vec[PRIO_RIGHT]  = btnRight;
    end
    pend_d      = ~strobe_q & (pend_q | btn_vec);
    grav_pend_d = ~strobe_q[PRIO_DOWN] & (grav_pend_q | grav_tick);
    if (enter_spawn) begin
      pend_d      = '0;
      grav_pend_d = 1'b0;
    end

    // Decide the strobe one cycle ahead so it is registered in PLAY.
    req            = pend_d;
    req[PRIO_DOWN] = pend_d[PRIO_DOWN] | grav_pend_d;
    if (state_d == ST_PLAY) strobe_d = pick_cmd(req);

    next_block_d = enter_spawn;
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      strobe_q     <= '0;
      grav_pend_q  <= 1'b0;
      shape_q      <= '0;
      block_type_q <= '0;
      score_q      <= '0;
      next_block_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      strobe_q     <= strobe_d;
      grav_pend_q  <= grav_pend_d;
      shape_q      <= shape_d;
      block_type_q <= block_type_d;
      score_q      <= score_d;
      next_block_q <= next_block_d;
      game_over_q  <= game_over_d;
    end
  end

  assign leftTrue      = strobe_q[PRIO_LEFT];
  assign rightTrue     = strobe_q[PRIO_RIGHT];
  assign downTrue      = strobe_q[PRIO_DOWN];
  assign rotateTrue    = strobe_q[PRIO_ROTATE];
  assign nextBlockTrue = next_block_q;
  assign blockType     = block_type_q;
  assign gameOver      = game_over_q;
  assign score         = score_q;

endmodule
